// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Round-robin, burst-bounded arbiter sharing one fifo write port
//               between two producers; acceptance is gated on fifo full.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [31:0]      data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [31:0]      data1,
    output logic             ack1,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [31:0]      fifo_d_in,
    output logic [1:0]       gnt,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    localparam logic [3:0] c_burst_end = 4'(MAX_BURST - 1);

    state_t           r_state_q, w_state_d;
    logic             r_last_q, w_last_d;
    logic [3:0]       r_burst_q, w_burst_d;
    logic [CNT_W-1:0] r_cnt0_q, w_cnt0_d;
    logic [CNT_W-1:0] r_cnt1_q, w_cnt1_d;

    logic w_xfer0;
    logic w_xfer1;
    logic w_xfer;
    logic w_burst_last;

    always_comb begin
        ack0       = (r_state_q == ST_G0) & ~fifo_full;
        ack1       = (r_state_q == ST_G1) & ~fifo_full;
        w_xfer0    = req0 & ack0;
        w_xfer1    = req1 & ack1;
        w_xfer     = w_xfer0 | w_xfer1;
        fifo_wr_en = w_xfer;
        unique case (r_state_q)
            ST_G0:   fifo_d_in = data0;
            ST_G1:   fifo_d_in = data1;
            default: fifo_d_in = 32'h0;
        endcase
        w_burst_last = w_xfer & (r_burst_q == c_burst_end);
    end

    always_comb begin
        w_state_d = r_state_q;
        w_last_d  = r_last_q;
        w_burst_d = r_burst_q;
        w_cnt0_d  = r_cnt0_q;
        w_cnt1_d  = r_cnt1_q;

        // Tie in IDLE goes to whichever requester was not served last.
        unique case (r_state_q)
            ST_IDLE: begin
                if (req0 && (!req1 || r_last_q)) w_state_d = ST_G0;
                else if (req1)                   w_state_d = ST_G1;
            end
            ST_G0: begin
                if (!req0)                     w_state_d = req1 ? ST_G1 : ST_IDLE;
                else if (w_burst_last && req1) w_state_d = ST_G1;
            end
            ST_G1: begin
                if (!req1)                     w_state_d = req0 ? ST_G0 : ST_IDLE;
                else if (w_burst_last && req0) w_state_d = ST_G0;
            end
            default: w_state_d = ST_IDLE;
        endcase

        if (w_state_d != r_state_q) begin
            if (w_state_d == ST_G0) w_last_d = 1'b0;
            if (w_state_d == ST_G1) w_last_d = 1'b1;
        end

        // A lone requester keeps streaming, so the burst count wraps in place.
        if ((w_state_d != r_state_q) || w_burst_last) w_burst_d = 4'd0;
        else if (w_xfer)                               w_burst_d = r_burst_q + 4'd1;

        if (w_xfer0 && (r_cnt0_q != {CNT_W{1'b1}})) w_cnt0_d = r_cnt0_q + CNT_W'(1);
        if (w_xfer1 && (r_cnt1_q != {CNT_W{1'b1}})) w_cnt1_d = r_cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q <= ST_IDLE;
            r_last_q  <= 1'b1;
            r_burst_q <= 4'd0;
            r_cnt0_q  <= '0;
            r_cnt1_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_last_q  <= w_last_d;
            r_burst_q <= w_burst_d;
            r_cnt0_q  <= w_cnt0_d;
            r_cnt1_q  <= w_cnt1_d;
        end
    end

    assign gnt  = r_state_q;
    assign cnt0 = r_cnt0_q;
    assign cnt1 = r_cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Scoreboard bench for fifo_wr_arb with an 8-deep fifo model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [31:0]      data0 = '0, data1 = '0;
    logic             ack0, ack1;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [31:0]      fifo_d_in;
    logic [1:0]       gnt;
    logic [CNT_W-1:0] cnt0, cnt1;

    typedef struct packed {
        logic        id;
        logic [31:0] d;
    } word_t;

    logic [31:0] p0_q[$];
    logic [31:0] p1_q[$];
    word_t       exp_q[$];

    int   n_checks = 0;
    int   n_errs   = 0;
    int   fcount   = 0;
    logic drain    = 1'b1;
    logic rd_one   = 1'b0;
    logic wr_err_seen = 1'b0;

    assign fifo_full = (fcount == 8);

    fifo_wr_arb #(.MAX_BURST(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_d_in(fifo_d_in),
        .gnt(gnt), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Producers, fifo model and scoreboard monitor share one timeline:
    // observe at negedge, update producer/fifo state just after posedge.
    always begin : drv_mon
        logic  f0, f1, wr, rd;
        word_t e;
        @(negedge clk);
        f0 = req0 & ack0;
        f1 = req1 & ack1;
        wr = fifo_wr_en;
        rd = (drain || rd_one) && (fcount > 0);
        if (wr && fcount == 8) wr_err_seen = 1'b1;
        if (wr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_write: got 0x%0h expected none", fifo_d_in);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", fifo_d_in, e.d);
                chk("wr_gnt", {30'd0, gnt}, e.id ? 32'd2 : 32'd1);
            end
        end
        @(posedge clk);
        #1;
        if (f0 && p0_q.size() != 0) void'(p0_q.pop_front());
        if (f1 && p1_q.size() != 0) void'(p1_q.pop_front());
        if (!reset_n) fcount = 0;
        else          fcount = fcount + (wr ? 1 : 0) - (rd ? 1 : 0);
        req0  = (p0_q.size() != 0);
        data0 = req0 ? p0_q[0] : 32'h0;
        req1  = (p1_q.size() != 0);
        data1 = req1 ? p1_q[0] : 32'h0;
    end

    task automatic give(input logic id, input logic [31:0] d);
        if (id) p1_q.push_back(d);
        else    p0_q.push_back(d);
    endtask

    task automatic expect_w(input logic id, input logic [31:0] d);
        word_t e;
        e.id = id;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    // Idle negedges before the first write, then length of the unbroken run.
    task automatic wait_burst(input string name, input int exp_delay, input int exp_run);
        int   miss = 0;
        int   run  = 0;
        logic hit  = 1'b0;
        while (!hit && miss < 30) begin
            @(negedge clk);
            if (fifo_wr_en) hit = 1'b1;
            else            miss++;
        end
        chk({name, "_delay"}, miss, exp_delay);
        if (hit) begin
            run = 1;
            @(negedge clk);
            while (fifo_wr_en && run < 40) begin
                run++;
                @(negedge clk);
            end
        end
        chk({name, "_run"}, run, exp_run);
    endtask

    initial begin
        int t;
        // Reset defaults
        #12;
        chk("rst_gnt", {30'd0, gnt}, 0);
        chk("rst_ack", {30'd0, ack1, ack0}, 0);
        chk("rst_cnt", {24'd0, cnt1, cnt0}, 0);
        @(posedge clk); #2 reset_n = 1'b1;

        // Single requester
        @(posedge clk); #2;
        for (int i = 0; i < 6; i++) begin
            give(0, 32'hA0 + i);
            expect_w(0, 32'hA0 + i);
        end
        wait_burst("single", 2, 6);
        chk("single_gnt", {30'd0, gnt}, 1);
        chk("single_cnt0", {28'd0, cnt0}, 6);
        repeat (2) @(negedge clk);
        chk("single_idle", {30'd0, gnt}, 0);

        // Asynchronous reset mid-burst
        @(posedge clk); #2;
        for (int i = 0; i < 6; i++) give(0, 32'hD0 + i);
        expect_w(0, 32'hD0);
        expect_w(0, 32'hD1);
        repeat (4) @(posedge clk);
        #2 chk("pre_rst_gnt", {30'd0, gnt}, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_ack", {30'd0, ack1, ack0}, 0);
        chk("mid_rst_wr", {31'd0, fifo_wr_en}, 0);
        chk("mid_rst_gnt", {30'd0, gnt}, 0);
        chk("mid_rst_cnt", {24'd0, cnt1, cnt0}, 0);
        chk("mid_rst_sb", exp_q.size(), 0);
        p0_q.delete();
        @(posedge clk); #2 reset_n = 1'b1;

        // Round-robin, both requesters from IDLE; requester 0 wins the tie
        @(posedge clk); #2;
        for (int i = 0; i < 8; i++) give(0, 32'hB0 + i);
        for (int i = 0; i < 4; i++) give(1, 32'hC0 + i);
        for (int i = 0; i < 4; i++) expect_w(0, 32'hB0 + i);
        for (int i = 0; i < 4; i++) expect_w(1, 32'hC0 + i);
        for (int i = 4; i < 8; i++) expect_w(0, 32'hB0 + i);
        wait_burst("rr", 2, 12);
        chk("rr_cnt0", {28'd0, cnt0}, 8);
        chk("rr_cnt1", {28'd0, cnt1}, 4);
        repeat (3) @(negedge clk);

        // Full backpressure into an undrained fifo
        drain = 1'b0;
        @(posedge clk); #2;
        for (int i = 0; i < 9; i++) begin
            give(1, 32'hE0 + i);
            expect_w(1, 32'hE0 + i);
        end
        wait_burst("full", 2, 8);
        repeat (2) @(negedge clk);
        chk("full_flag", {31'd0, fifo_full}, 1);
        chk("full_ack1", {31'd0, ack1}, 0);
        chk("full_gnt", {30'd0, gnt}, 2);
        @(posedge clk); #2 rd_one = 1'b1;
        @(negedge clk);
        @(posedge clk); #2 rd_one = 1'b0;
        @(negedge clk);
        chk("unfull_ack1", {31'd0, ack1}, 1);
        chk("unfull_wr", {31'd0, fifo_wr_en}, 1);
        @(negedge clk);
        chk("full_cnt1", {28'd0, cnt1}, 13);
        chk("no_wr_err", {31'd0, wr_err_seen}, 0);
        drain = 1'b1;
        repeat (12) @(negedge clk);

        // Early release: requester 0 drops after 2 words while requester 1 waits
        @(posedge clk); #2;
        give(0, 32'hF0);
        give(0, 32'hF1);
        for (int i = 0; i < 4; i++) give(1, 32'h90 + i);
        expect_w(0, 32'hF0);
        expect_w(0, 32'hF1);
        for (int i = 0; i < 4; i++) expect_w(1, 32'h90 + i);
        wait_burst("early0", 2, 2);
        chk("early_gnt", {30'd0, gnt}, 1);
        wait_burst("early1", 0, 4);
        chk("early_cnt1_sat", {28'd0, cnt1}, 15);
        chk("early_cnt0", {28'd0, cnt0}, 10);

        // Saturation of cnt0
        @(posedge clk); #2;
        for (int i = 0; i < 20; i++) begin
            give(0, 32'h100 + i);
            expect_w(0, 32'h100 + i);
        end
        wait_burst("sat", 2, 20);
        chk("sat_cnt0", {28'd0, cnt0}, 15);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
